// File: rtl/posit_round_pipe.sv
// posit_round_pipe: 3-stage posit encode/round unit.
// S1 splits the scale into regime/exponent and flags saturation.
// S2 assembles the regime|exp|frac magnitude and extracts L/G/S.
// S3 rounds to nearest-even, clamps to minpos/maxpos, applies sign/specials.
// Optional statistics outputs (out_inexact, inexact_cnt) are present only
// when POSIT_ROUND_STATS_EN is defined.
//
// Handshake: a beat moves across an interface on a rising clk edge where
// valid && ready are both high. A stage register loads whenever it is empty
// or its successor loads in the same cycle, so bubbles collapse. in_ready is
// high when S1 can load. out_valid/out_posit hold while out_ready is low.
module posit_round_pipe #(
  parameter int N  = 32,
  parameter int ES = 2,
  parameter int FW = 2*N-1,
  parameter int SW = $clog2(N)+ES+2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic          in_zero,
  input  logic          in_nar,
  input  logic [SW-1:0] in_scale,
  input  logic [FW-1:0] in_frac,
  input  logic          in_sticky,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_posit
`ifdef POSIT_ROUND_STATS_EN
  ,
  output logic          out_inexact,
  output logic [15:0]   inexact_cnt
`endif
);

  localparam int SHW = $clog2(N);     // regime shift amount width
  localparam int EFW = ES+FW;         // exponent + fraction bits
  localparam int EW  = 2+EFW+N-2;     // assembled field incl. shift room
  localparam logic signed [SW-1:0] KMAX = SW'(N-2);
  localparam logic signed [SW-1:0] KMIN = SW'(-(N-2));
  localparam logic [EW-1:0] ONES = '1;
  localparam logic [N-1:0] MAXPOS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINPOS = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] NAR    = {1'b1, {(N-1){1'b0}}};

  // Stage valids and advance enables
  logic v1, v2;
  logic load1, load2, load3;

  // S1 registers
  logic           sign1, zero1, nar1, smax1, smin1, fill1, sticky1;
  logic [SHW-1:0] sh1;
  logic [EFW-1:0] ef1;

  // S2 registers
  logic           sign2, zero2, nar2, smax2, smin2, g2, s2;
  logic [N-1:0]   kept2;

  // S1 combinational decode
  logic signed [SW-1:0] k_c;
  logic                 smax_c, smin_c;
  logic [SHW-1:0]       sh_c;
  logic [EFW-1:0]       ef_c;

  // S2 combinational assembly
  logic [EW-1:0] base_c, shifted_c;
  logic [N-1:0]  kept_c;
  logic          g_c, s_c;

  // S3 combinational rounding
  logic          round_c;
  logic [N:0]    sum_c;
  logic [N-1:0]  mag_c, posit_c;

  assign load3    = !out_valid || out_ready;
  assign load2    = !v2 || load3;
  assign load1    = !v1 || load2;
  assign in_ready = load1;

  // S1: k = floor(scale / 2^ES); run length minus two becomes the shift
  always_comb begin
    k_c    = $signed(in_scale) >>> ES;
    smax_c = k_c > KMAX;
    smin_c = k_c < KMIN;
    // k>=0 -> R-2 = k ; k<0 -> R-2 = -k-1 = ~k
    sh_c   = k_c[SW-1] ? ~k_c[SHW-1:0] : k_c[SHW-1:0];
    ef_c   = EFW'({in_scale, in_frac});
  end

  // S2: seed "10"/"01" then shift right filling with the regime bit
  always_comb begin
    base_c    = {(fill1 ? 2'b10 : 2'b01), ef1, {(N-2){1'b0}}};
    shifted_c = (base_c >> sh1) | (fill1 ? ~(ONES >> sh1) : '0);
    kept_c    = {1'b0, shifted_c[EW-1 -: N-1]};
    g_c       = shifted_c[EW-N];
    s_c       = (|shifted_c[EW-N-1:0]) | sticky1;
  end

  // S3: round to nearest even, clamp, then apply sign and specials
  always_comb begin
    round_c = g2 & (kept2[0] | s2);
    sum_c   = {1'b0, kept2} + {{N{1'b0}}, round_c};
    if (smax2)                      mag_c = MAXPOS;
    else if (smin2)                 mag_c = MINPOS;
    else if (sum_c[N] || sum_c[N-1]) mag_c = MAXPOS;
    else if (sum_c == '0)           mag_c = MINPOS;
    else                            mag_c = sum_c[N-1:0];
    if (nar2)       posit_c = NAR;
    else if (zero2) posit_c = '0;
    else if (sign2) posit_c = -mag_c;
    else            posit_c = mag_c;
  end

  // Pipeline registers; data captured only with a valid beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; sign1 <= 1'b0; zero1 <= 1'b0; nar1 <= 1'b0;
      smax1 <= 1'b0; smin1 <= 1'b0; fill1 <= 1'b0; sticky1 <= 1'b0;
      sh1 <= '0; ef1 <= '0;
      v2 <= 1'b0; sign2 <= 1'b0; zero2 <= 1'b0; nar2 <= 1'b0;
      smax2 <= 1'b0; smin2 <= 1'b0; g2 <= 1'b0; s2 <= 1'b0; kept2 <= '0;
      out_valid <= 1'b0; out_posit <= '0;
    end else begin
      if (load1) begin
        v1 <= in_valid;
        if (in_valid) begin
          sign1 <= in_sign; zero1 <= in_zero; nar1 <= in_nar;
          smax1 <= smax_c; smin1 <= smin_c; fill1 <= ~k_c[SW-1];
          sh1 <= sh_c; ef1 <= ef_c; sticky1 <= in_sticky;
        end
      end
      if (load2) begin
        v2 <= v1;
        if (v1) begin
          sign2 <= sign1; zero2 <= zero1; nar2 <= nar1;
          smax2 <= smax1; smin2 <= smin1;
          kept2 <= kept_c; g2 <= g_c; s2 <= s_c;
        end
      end
      if (load3) begin
        out_valid <= v2;
        if (v2) out_posit <= posit_c;
      end
    end
  end

`ifdef POSIT_ROUND_STATS_EN
  // Inexact flag rides with the output beat; saturating beat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_inexact <= 1'b0;
      inexact_cnt <= '0;
    end else begin
      if (load3 && v2)
        out_inexact <= !(nar2 || zero2) && (smax2 || smin2 || g2 || s2);
      if (out_valid && out_ready && out_inexact && inexact_cnt != 16'hFFFF)
        inexact_cnt <= inexact_cnt + 16'd1;
    end
  end
`else
  // No statistics outputs in this build.
`endif

endmodule

// File: tb/tb_posit_round_pipe.sv
// Bench for posit_round_pipe (N=32, ES=2): vector table, backpressure,
// latency, reset and randomized beats against a bit-list reference model.
module tb_posit_round_pipe;
  localparam int N = 32;
  localparam int ES = 2;
  localparam int FW = 63;
  localparam int SW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_sign, in_zero, in_nar, in_sticky;
  logic [SW-1:0] in_scale;
  logic [FW-1:0] in_frac;
  logic          out_valid, out_ready;
  logic [N-1:0]  out_posit;

  posit_round_pipe #(.N(N), .ES(ES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_zero(in_zero), .in_nar(in_nar),
    .in_scale(in_scale), .in_frac(in_frac), .in_sticky(in_sticky),
    .out_valid(out_valid), .out_ready(out_ready), .out_posit(out_posit)
  );

  // Clock
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        sign;
    logic        zero;
    logic        nar;
    int          scale;
    logic [62:0] frac;
    logic        sticky;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[16];

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference: write the posit bit string as a list, keep N-1, round RNE
  function automatic logic [31:0] ref_posit(input logic s, input logic z,
      input logic na, input int scale, input logic [62:0] frac,
      input logic st);
    int k, e;
    bit bits[$];
    longint kept;
    bit g, sb;
    logic [31:0] mag;
    if (na) return 32'h8000_0000;
    if (z) return 32'h0;
    if (scale >= 0) k = scale / 4;
    else k = -((-scale + 3) / 4);
    e = scale - 4*k;
    if (k > 30) mag = 32'h7FFF_FFFF;
    else if (k < -30) mag = 32'h1;
    else begin
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) bits.push_back(1'b1);
        bits.push_back(1'b0);
      end else begin
        for (int i = 0; i < -k; i++) bits.push_back(1'b0);
        bits.push_back(1'b1);
      end
      bits.push_back(((e >> 1) & 1) != 0);
      bits.push_back((e & 1) != 0);
      for (int i = 62; i >= 0; i--) bits.push_back(frac[i]);
      kept = 0;
      for (int i = 0; i < 31; i++) kept = kept * 2 + longint'(bits[i]);
      g = bits[31];
      sb = st;
      for (int i = 32; i < bits.size(); i++) sb = sb | bits[i];
      if (g && ((kept % 2) == 1 || sb)) kept++;
      if (kept >= 64'h8000_0000) kept = 64'h7FFF_FFFF;
      if (kept == 0) kept = 1;
      mag = kept[31:0];
    end
    return s ? -mag : mag;
  endfunction

  // Driver: present one beat, wait (bounded) for acceptance
  task automatic send_beat(input logic s, input logic z, input logic na,
      input int sc, input logic [62:0] fr, input logic st,
      input logic [31:0] ex);
    int c;
    bit ok;
    in_sign = s; in_zero = z; in_nar = na; in_scale = sc[SW-1:0];
    in_frac = fr; in_sticky = st; in_valid = 1'b1;
    c = 0; ok = 0;
    while (!ok && c < 100) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      c++;
    end
    if (ok) exp_q.push_back(ex);
    else check(0, "accept_timeout", 32'(c), 32'd100);
    in_valid = 1'b0;
    in_frac = {$urandom(), $urandom()};
  endtask

  task automatic wait_drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 300) begin
      @(posedge clk);
      c++;
    end
    #1;
    if (exp_q.size() != 0) begin
      check(0, "drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic latency_check(input string name);
    int n;
    in_sign = 0; in_zero = 0; in_nar = 0; in_scale = '0;
    in_frac = '0; in_sticky = 0; in_valid = 1'b1;
    exp_q.push_back(32'h4000_0000);
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    check(n == 3, name, 32'(n), 32'd3);
    wait_drain();
  endtask

  // Scoreboard / monitor: ordered compare and stall-hold check
  logic        held = 1'b0;
  logic [31:0] held_val;
  logic [31:0] mon_exp;
  always @(negedge clk) begin
    if (rst) held = 1'b0;
    else begin
      if (held)
        check(out_valid === 1'b1 && out_posit === held_val, "stall_hold",
              out_posit, held_val);
      if (out_valid === 1'b1 && out_ready) begin
        if (exp_q.size() == 0) check(0, "unexpected_out", out_posit, 32'h0);
        else begin
          mon_exp = exp_q.pop_front();
          check(out_posit === mon_exp, "out_posit", out_posit, mon_exp);
        end
      end
      held = out_valid && !out_ready;
      held_val = out_posit;
    end
  end

  logic [31:0] bp_exp[5];
  bit          stop_rdy;

  initial begin
    logic [63:0] rnd;
    logic [62:0] f35, f36_35;
    int sc;
    logic s, z, na, st;
    f35 = 63'd1 << 35;
    f36_35 = 63'd3 << 35;
    vecs[0]  = '{1'b0, 1'b0, 1'b0,    0, 63'd0,  1'b0, 32'h4000_0000};
    vecs[1]  = '{1'b1, 1'b0, 1'b0,    0, 63'd0,  1'b0, 32'hC000_0000};
    vecs[2]  = '{1'b0, 1'b0, 1'b0,    0, f35,    1'b0, 32'h4000_0000};
    vecs[3]  = '{1'b0, 1'b0, 1'b0,    0, f35,    1'b1, 32'h4000_0001};
    vecs[4]  = '{1'b0, 1'b0, 1'b0,  200, 63'd0,  1'b0, 32'h7FFF_FFFF};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, -200, 63'd0,  1'b0, 32'h0000_0001};
    vecs[6]  = '{1'b1, 1'b0, 1'b0,  200, 63'd0,  1'b0, 32'h8000_0001};
    vecs[7]  = '{1'b0, 1'b1, 1'b1,    0, 63'd0,  1'b0, 32'h8000_0000};
    vecs[8]  = '{1'b1, 1'b1, 1'b0,    5, 63'd7,  1'b1, 32'h0000_0000};
    vecs[9]  = '{1'b0, 1'b0, 1'b0,   -1, 63'd0,  1'b0, 32'h3800_0000};
    vecs[10] = '{1'b0, 1'b0, 1'b0,  120, 63'd0,  1'b0, 32'h7FFF_FFFF};
    vecs[11] = '{1'b0, 1'b0, 1'b0, -120, 63'd0,  1'b0, 32'h0000_0001};
    vecs[12] = '{1'b0, 1'b0, 1'b0, -117, 63'd0,  1'b0, 32'h0000_0002};
    vecs[13] = '{1'b0, 1'b0, 1'b0,    0, f36_35, 1'b0, 32'h4000_0002};
    vecs[14] = '{1'b1, 1'b0, 1'b0,    0, f35,    1'b1, 32'hBFFF_FFFF};
    vecs[15] = '{1'b1, 1'b0, 1'b0, -124, 63'd0,  1'b0, 32'hFFFF_FFFF};
    bp_exp = '{32'h4000_0000, 32'h4800_0000, 32'h5000_0000,
               32'h5800_0000, 32'h6000_0000};

    // Reset
    rst = 1'b1; in_valid = 0; in_sign = 0; in_zero = 0; in_nar = 0;
    in_scale = '0; in_frac = '0; in_sticky = 0; out_ready = 1'b1;
    #1;
    check(out_valid === 1'b0, "rst_out_valid", 32'(out_valid), 32'd0);
    check(out_posit === 32'h0, "rst_out_posit", out_posit, 32'h0);
    check(in_ready === 1'b1, "rst_in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Latency from an empty pipeline
    latency_check("latency");

    // Vector table
    for (int i = 0; i < 16; i++)
      send_beat(vecs[i].sign, vecs[i].zero, vecs[i].nar, vecs[i].scale,
                vecs[i].frac, vecs[i].sticky, vecs[i].exp);
    wait_drain();

    // Backpressure: 5 back-to-back beats with a stalled output
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send_beat(0, 0, 0, i, 63'd0, 0, bp_exp[i]);
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check(in_ready === 1'b0, "bp_in_ready", 32'(in_ready), 32'd0);
        check(out_valid === 1'b1, "bp_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();

    // Randomized beats with random output stalls
    stop_rdy = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          s  = $urandom_range(0, 1) != 0;
          z  = $urandom_range(0, 15) == 0;
          na = $urandom_range(0, 15) == 0;
          st = $urandom_range(0, 1) != 0;
          if ($urandom_range(0, 3) == 0) sc = int'($urandom_range(0, 511)) - 256;
          else sc = int'($urandom_range(0, 260)) - 130;
          rnd = {$urandom(), $urandom()};
          send_beat(s, z, na, sc, rnd[62:0], st,
                    ref_posit(s, z, na, sc, rnd[62:0], st));
        end
        stop_rdy = 1;
      end
      begin
        while (!stop_rdy) begin
          @(posedge clk);
          #1 out_ready = $urandom_range(0, 3) != 0;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();

    // Reset with three beats in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_beat(0, 0, 0, i, 63'd0, 0, bp_exp[i]);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check(out_valid === 1'b0, "midrst_out_valid", 32'(out_valid), 32'd0);
    check(out_posit === 32'h0, "midrst_out_posit", out_posit, 32'h0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    check(in_ready === 1'b1, "postrst_in_ready", 32'(in_ready), 32'd1);
    latency_check("postrst_latency");
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/posit_round_pipe.md
Name: posit_round_pipe

Overview:
- Pipelined posit encode/round unit, parametrised in N and ES.
- Takes an unpacked result from the divider/multiplier datapath: sign, signed total scale, normalised fraction, sticky and special flags.
- Produces an N-bit posit rounded to nearest, ties to even, with minpos/maxpos saturation.
- 3-stage pipeline with valid/ready handshake on both sides; sits between the arithmetic core and the PPU result register.

Parameters:
- N, 32, posit width (8..64).
- ES, 2, exponent field width (0..4).
- FW, 2*N-1, input fraction width; hidden 1 is implied and not supplied.
- SW, $clog2(N)+ES+2, signed scale width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat.
- in_sign  in  1  result sign.
- in_zero  in  1  result is zero.
- in_nar  in  1  result is NaR.
- in_scale  in  SW  signed scale, equal to k*2^ES + e.
- in_frac  in  FW  fraction, MSB = 2^-1.
- in_sticky  in  1  OR of fraction bits already discarded upstream.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_posit  out  N  encoded posit.

Behaviour:
- Reset: out_valid=0, out_posit=0, all stage valids=0. in_ready=1 whenever the S1 register is empty or will advance.
- Transfers occur when valid&&ready are high at a rising clk edge.
- Stage advance rule: stage i loads when it is empty or stage i+1 loads. Bubbles collapse.
- Capacity 3 beats. Latency 3 cycles from accept to out_valid with out_ready held high. Full throughput: 1 beat/cycle.
- Ordering is preserved. No beat is dropped or duplicated under any stall pattern.
- S1, decompose:
  - k = in_scale >>> ES (arithmetic), e = in_scale[ES-1:0].
  - Clamp: k > N-2 sets sat_max; k < -(N-2) sets sat_min.
  - Regime run length R = k+2 for k≥0, otherwise -k+1.
- S2, assemble:
  - Build the unsigned magnitude {0, regime, e, frac} in a 2N+ES+2-bit field, then right-shift so the regime starts at bit N-2.
  - L = bit 0 of the kept N-bit magnitude; G = first dropped bit; S = OR of the remaining dropped bits | in_sticky.
- S3, round and sign:
  - mag = kept + (G & (L | S)).
  - If mag==0 for a nonzero input, force mag=minpos (1).
  - If mag ≥ 2^(N-1), force mag=maxpos (2^(N-1)-1).
  - sat_max forces maxpos; sat_min forces minpos. Neither is ever rounded.
  - out_posit = in_sign ? -mag : mag (two's complement over N bits).
- Specials:
  - in_nar gives 1 followed by N-1 zeros. in_nar has priority over in_zero.
  - in_zero gives 0.
  - Sign is ignored for both.
- Special and saturation flags travel with their beat through all stages.
- out_posit and out_valid hold stable while out_valid && !out_ready.
- Reset mid-operation: all in-flight beats are discarded and outputs return to reset values immediately (asynchronous).
- Inputs with in_valid=0 are ignored. X on the data inputs must not propagate into valid state.

Optional Feature:
- Macro: POSIT_ROUND_STATS_EN.
- Defined:
  - Adds output out_inexact (1 bit), aligned with out_posit. It is 1 when G|S was set or saturation occurred, and 0 for specials.
  - Adds output inexact_cnt (16 bits): count of inexact beats transferred at the output. Saturates at 16'hFFFF and resets to 0.
- Undefined: both ports and all related logic are absent. All other behaviour is identical.

Test Plan (N=32, ES=2):
- Basic encode: sign=0, scale=0, frac=0 -> 0x40000000 after 3 cycles. Same input with sign=1 -> 0xC0000000.
- Tie to even: scale=0, frac[35]=1 only, sticky=0 -> 0x40000000. Same input with sticky=1 -> 0x40000001.
- Saturation: scale=+200 -> 0x7FFFFFFF. scale=-200 -> 0x00000001. With sign=1 and scale=+200 -> 0x80000001.
- Specials: nar=1 with zero=1 -> 0x80000000. zero=1, sign=1 -> 0x00000000.
- Backpressure:
  - Stimulus: 5 back-to-back beats with scale=0..4 and frac=0; out_ready=0 for cycles 2-7, then 1.
  - Expected: in_ready drops after 3 beats are held; outputs 0x40000000, 0x48000000, 0x50000000, 0x58000000, 0x60000000 in order; out_posit stable while stalled.
- Reset: assert rst with 3 beats in flight -> out_valid=0 at once. After release the pipeline is empty and the next beat emerges after 3 cycles.
